// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder/subtractor split into SLICE-bit
// pipeline stages (STAGES = WIDTH/SLICE), one register stage per slice.
// The carry is handed from stage to stage. Upper operand slices travel ahead
// of the adder (input skew), and finished lower sum slices travel with it
// (output de-skew). Valid/ready handshake on both sides. The whole pipe holds
// while the output is valid and not accepted.
// Optional feature: define ADDER_OVERFLOW_EN to add the signed 'overflow' output.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = WIDTH / SLICE;

  // Per-stage state: valid bit, carry out of the slice just added, the full
  // operands (b already conditioned for subtract) and the partial sum.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Working values for the stage currently being evaluated in the loop.
  logic              advance_s;
  logic              st_valid_s;
  logic              st_cin_s;
  logic [WIDTH-1:0]  st_a_s;
  logic [WIDTH-1:0]  st_b_s;
  logic [WIDTH-1:0]  st_sum_s;
  logic [SLICE:0]    slice_sum_s;

`ifdef ADDER_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  // The pipe moves only when the output slot is empty or being drained.
  // in_ready depends only on registered state and out_ready, never on in_valid.
  always_comb begin
    advance_s = !valid_q[STAGES-1] || out_ready;
    in_ready  = advance_s;
  end

  // Next state for every stage: add slice k with the carry of the same
  // operation from the previous stage. Otherwise hold everything.
  always_comb begin
    valid_d     = valid_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    st_valid_s  = 1'b0;
    st_cin_s    = 1'b0;
    st_a_s      = {WIDTH{1'b0}};
    st_b_s      = {WIDTH{1'b0}};
    st_sum_s    = {WIDTH{1'b0}};
    slice_sum_s = {(SLICE+1){1'b0}};
`ifdef ADDER_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          // Subtract is a + ~b + 1: invert b and use the carry-in of slice 0.
          st_valid_s = in_valid;
          st_a_s     = a;
          st_b_s     = sub ? ~b : b;
          st_sum_s   = {WIDTH{1'b0}};
          st_cin_s   = sub;
        end else begin
          st_valid_s = valid_q[k-1];
          st_a_s     = a_q[k-1];
          st_b_s     = b_q[k-1];
          st_sum_s   = sum_q[k-1];
          st_cin_s   = carry_q[k-1];
        end
        slice_sum_s = {1'b0, st_a_s[k*SLICE +: SLICE]}
                    + {1'b0, st_b_s[k*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, st_cin_s};
        st_sum_s[k*SLICE +: SLICE] = slice_sum_s[SLICE-1:0];
        valid_d[k] = st_valid_s;
        carry_d[k] = slice_sum_s[SLICE];
        a_d[k]     = st_a_s;
        b_d[k]     = st_b_s;
        sum_d[k]   = st_sum_s;
`ifdef ADDER_OVERFLOW_EN
        // Carry into the MSB is recovered as a^b^sum at that bit.
        if (k == STAGES-1) begin
          ovf_d = st_a_s[WIDTH-1] ^ st_b_s[WIDTH-1] ^ st_sum_s[WIDTH-1]
                ^ slice_sum_s[SLICE];
        end else begin
          ovf_d = ovf_d;
        end
`endif
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage registers. Reset discards every in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      a_q     <= '{default: {WIDTH{1'b0}}};
      b_q     <= '{default: {WIDTH{1'b0}}};
      sum_q   <= '{default: {WIDTH{1'b0}}};
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

`ifdef ADDER_OVERFLOW_EN
  // Signed overflow flag, registered alongside the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  // The last stage register is the output register.
  assign out_valid = valid_q[STAGES-1];
  assign result    = sum_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=8, SLICE=4, latency 2).
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
`ifdef ADDER_OVERFLOW_EN
  logic       overflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry)
`ifdef ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation; entered and left at posedge+1.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_sub, input logic [7:0] exp_res, input logic exp_c);
    a = op_a; b = op_b; sub = op_sub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    check_eq({tag, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

`ifdef ADDER_OVERFLOW_EN
  task automatic run_ovf(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic op_sub, input logic [7:0] exp_res, input logic exp_ov);
    a = op_a; b = op_b; sub = op_sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
    @(posedge clk); #1;
  endtask
`endif

  // Back-to-back stream: operands and hand-computed {carry,result}.
  logic [7:0] s_a   [4] = '{8'h12, 8'hF0, 8'h30, 8'h9A};
  logic [7:0] s_b   [4] = '{8'h34, 8'h20, 8'h31, 8'h1A};
  logic       s_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] s_exp [4] = '{9'h046, 9'h110, 9'h0FF, 9'h180};

  initial begin
    int  tx;
    int  rx;
    logic acc;
    logic hs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; sub = 1'b0;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_carry", {31'd0, carry}, 32'd0);
    @(posedge clk); #1;

    run_op("add_10_2",  8'd10,  8'd2,   1'b0, 8'h0C, 1'b0);
    run_op("add_ff_01", 8'hFF,  8'h01,  1'b0, 8'h00, 1'b1);
    run_op("sub_05_07", 8'h05,  8'h07,  1'b1, 8'hFE, 1'b0);
    run_op("sub_07_05", 8'h07,  8'h05,  1'b1, 8'h02, 1'b1);
    run_op("sub_00_00", 8'h00,  8'h00,  1'b1, 8'h00, 1'b1);
    run_op("add_0f_01", 8'h0F,  8'h01,  1'b0, 8'h10, 1'b0);

`ifdef ADDER_OVERFLOW_EN
    run_ovf("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
    run_ovf("ovf_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
    run_ovf("ovf_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
`endif

    // Stream of four with out_ready low in cycles 3..5.
    tx = 0; rx = 0;
    for (int c = 0; c < 20 && rx < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (tx < 4) begin
        in_valid = 1'b1; a = s_a[tx]; b = s_b[tx]; sub = s_sub[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c <= 6) begin
        check_eq($sformatf("stall_in_ready_c%0d", c), {31'd0, in_ready},
                 (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
      end
      if (out_valid) begin
        check_eq($sformatf("stall_out%0d_c%0d", rx, c), {23'd0, carry, result}, {23'd0, s_exp[rx]});
      end
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) tx++;
      if (hs)  rx++;
    end
    in_valid = 1'b0;
    check_eq("stall_delivered", rx, 32'd4);
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("stall_no_dup_c%0d", c), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset with two operations in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("inflight_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_async_result", {24'd0, result}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("rst_no_stale_c%0d", c), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
